pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 99 +++++++++
 tb/tb_pipe_stage_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register, 1-cycle latency; SKID_EN=1 adds a skid entry so in_ready is a flop.
// Backpressure: skid mode stalls upstream only when both entries are held; register mode passes out_ready through.
module pipe_stage_buf #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter bit                    SKID_EN     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  rdy_q, rdy_d;
  logic                  in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign occupancy = 2'(state_q);
  assign out_data  = main_q;
  assign in_ready  = SKID_EN ? rdy_q : (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else if (SKID_EN) begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = MAIN;
            main_d  = in_data;
          end
        end
        MAIN: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain into main can happen
          if (out_xfer) begin
            state_d = MAIN;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      if (in_xfer) begin
        state_d = MAIN;
        main_d  = in_data;
      end else if (out_xfer) begin
        state_d = EMPTY;
      end
    end
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Four stages (skid/register x 64-bit/1-bit) driven side by side; a queue model per stage
// predicts occupancy, handshakes and data, and a negedge monitor compares against it.
module tb_pipe_stage_buf;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid_a  [N];
  logic        in_ready_a  [N];
  logic [63:0] in_data_a   [N];
  logic        out_valid_a [N];
  logic        out_ready_a [N];
  logic [63:0] out_data_a  [N];
  logic [1:0]  occ_a       [N];

  logic [63:0] exp_q [N][$];
  logic [63:0] tx_q  [N][$];
  logic [63:0] idle  [N];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W  = (g >= 2) ? 1 : 64;
    localparam bit SK = (g % 2 == 0);
    logic [W-1:0] id, od;
    assign id            = in_data_a[g][W-1:0];
    assign out_data_a[g] = 64'(od);
    pipe_stage_buf #(.DATA_WIDTH(W), .SKID_EN(SK)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (id),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (od),
      .occupancy (occ_a[g])
    );
  end

  function automatic bit is_skid(input int i);
    return (i % 2 == 0);
  endfunction

  function automatic logic [63:0] mask_of(input int i);
    return (i >= 2) ? 64'h1 : {64{1'b1}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Monitor: the model says a stage holds exactly the accepted-but-unsent beats, in order.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int          n = exp_q[i].size();
      automatic logic [63:0] v;
      chk($sformatf("occupancy[%0d]", i), 64'(occ_a[i]), 64'(n));
      chk($sformatf("out_valid[%0d]", i), 64'(out_valid_a[i]), 64'(n != 0));
      chk($sformatf("in_ready[%0d]", i), 64'(in_ready_a[i]),
          is_skid(i) ? 64'(n < 2) : 64'((n == 0) || out_ready_a[i]));
      chk($sformatf("out_data[%0d]", i), out_data_a[i], (n != 0) ? exp_q[i][0] : idle[i]);
      if (out_valid_a[i] && out_ready_a[i] && n != 0) begin
        v = exp_q[i].pop_front();
        if (exp_q[i].size() == 0) idle[i] = v;
      end
    end
  end

  task automatic cyc(input int vpct, input int rpct, input bit fl);
    for (int i = 0; i < N; i++) begin
      in_valid_a[i]  = (tx_q[i].size() != 0) && ($urandom_range(99) < vpct);
      in_data_a[i]   = (tx_q[i].size() != 0) ? tx_q[i][0] : 64'h0;
      out_ready_a[i] = ($urandom_range(99) < rpct);
    end
    flush = fl;
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst && in_valid_a[i] && in_ready_a[i]) begin
        automatic logic [63:0] v = tx_q[i].pop_front();
        if (!fl) exp_q[i].push_back(v & mask_of(i));
      end
      if (fl) begin
        exp_q[i].delete();
        idle[i] = 64'h0;
      end
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic load(input logic [63:0] v);
    for (int i = 0; i < N; i++) tx_q[i].push_back(v);
  endtask

  // Reset pulled between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      idle[i] = 64'h0;
    end
    #1;
    chk("async_occ", 64'(occ_a[0]), 64'd0);
    chk("async_valid", 64'(out_valid_a[0]), 64'd0);
    chk("async_data", out_data_a[0], 64'd0);
    chk("async_rdy", 64'(in_ready_a[0]), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) tx_q[i].delete();
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid_a[i]  = 1'b0;
      in_data_a[i]   = 64'h0;
      out_ready_a[i] = 1'b0;
      idle[i]        = 64'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    load(64'h11); load(64'h22); load(64'h33);
    cyc(100, 100, 0);
    chk("stream_first_data", out_data_a[0], 64'h11);
    chk("stream_first_occ", 64'(occ_a[0]), 64'd1);
    repeat (3) cyc(100, 100, 0);

    load(64'hA1); load(64'hA2);
    cyc(100, 0, 0);
    cyc(100, 0, 0);
    chk("full_occ", 64'(occ_a[0]), 64'd2);
    chk("full_rdy", 64'(in_ready_a[0]), 64'd0);
    chk("full_data", out_data_a[0], 64'hA1);
    cyc(100, 100, 0);
    chk("drain_data", out_data_a[0], 64'hA2);
    chk("drain_occ", 64'(occ_a[0]), 64'd1);
    repeat (4) cyc(100, 100, 0);

    load(64'hB1); load(64'hB2); load(64'hFF);
    cyc(100, 0, 0);
    cyc(100, 0, 0);
    cyc(100, 100, 1);
    chk("flush_occ", 64'(occ_a[0]), 64'd0);
    chk("flush_valid", 64'(out_valid_a[0]), 64'd0);
    chk("flush_data", out_data_a[0], 64'd0);
    for (int i = 0; i < N; i++) tx_q[i].delete();
    repeat (2) cyc(0, 100, 0);

    load(64'h5); load(64'h6); load(64'h7);
    cyc(100, 100, 0);
    cyc(100, 0, 0);
    cyc(100, 100, 0);
    repeat (4) cyc(100, 100, 0);

    load(64'hC1); load(64'hC2);
    cyc(100, 0, 0);
    cyc(100, 0, 0);
    async_reset();
    load(64'h42);
    cyc(100, 100, 0);
    chk("post_reset_valid", 64'(out_valid_a[0]), 64'd1);
    chk("post_reset_data", out_data_a[0], 64'h42);
    repeat (2) cyc(0, 100, 0);

    for (int p = 0; p < 4; p++) begin
      automatic int vp = (p == 2) ? 30 : ((p == 3) ? 60 : 90);
      automatic int rp = (p == 1) ? 30 : ((p == 3) ? 60 : 90);
      if (p == 2) async_reset();
      for (int c = 0; c < 2500; c++) begin
        for (int i = 0; i < N; i++)
          if (tx_q[i].size() < 2) tx_q[i].push_back({$urandom(), $urandom()});
        cyc(vp, rp, ($urandom_range(63) == 0));
      end
    end
    repeat (3) cyc(0, 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
